// File: rtl/rr_write_port_scheduler.sv
// ---------------------------------------------------------------------------
// rr_write_port_scheduler
//
// Round-robin scheduler that shares a single register-file write port among
// eight requesters. The current owner is presented as a 3-bit select plus an
// enable for the downstream 3-to-8 write-enable decoder, and as a matching
// one-hot grant vector back to the requesters. An owner keeps the port while
// it keeps requesting, for at most MAX_HOLD consecutive cycles, after which
// the port rotates to the next requester in round-robin order.
//
// Parameters
//   MAX_HOLD : maximum consecutive cycles one requester may own the port
//              (1..16)
//   CNT_W    : width of the hold counter, 2**CNT_W >= MAX_HOLD
//
// Ports
//   clock    in   1  rising-edge clock for all state
//   reset_n  in   1  asynchronous active-low reset
//   req      in   8  request vector, req[i] held by requester i until served
//   sel      out  3  index of the current (or most recent) owner
//   sel_en   out  1  high while a grant is active
//   gnt      out  8  one-hot grant, zero when no grant is active
//   done     out  1  pulses in the final cycle of every grant
//   busy     out  1  high while in the GRANT state (same as sel_en)
// ---------------------------------------------------------------------------
module rr_write_port_scheduler #(
  parameter int MAX_HOLD = 4,
  parameter int CNT_W    = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] req,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic [7:0] gnt,
  output logic       done,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       ptr_nxt;
  logic [2:0]       sel_nxt;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_nxt;

  logic [2:0]       search_base;
  logic             found;
  logic [2:0]       winner;
  logic             end_grant;

  // A running grant ends when its owner withdraws or has used its last
  // allowed cycle. This is also exactly when done pulses.
  assign end_grant = (state == GRANT) && (!req[sel] || (hold_cnt == HOLD_LAST));

  // Arbitration from IDLE starts at the stored pointer; a re-arbitration at
  // the end of a grant starts just past the outgoing owner. The outgoing
  // owner's bit needs no explicit masking: if it withdrew, its bit is
  // already zero, and if it timed out while still requesting it is only
  // reached again after every other index, which gives the sole-requester
  // re-grant for free.
  assign search_base = (state == GRANT) ? (sel + 3'd1) : ptr;

  // Rotating priority search: the first set bit at or after search_base,
  // wrapping 7 -> 0, wins.
  always_comb begin : arbiter
    logic [2:0] idx;
    found  = 1'b0;
    winner = search_base;
    idx    = search_base;
    for (int i = 0; i < 8; i++) begin
      idx = search_base + 3'(i);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Next-state logic. The pointer only advances when a grant finishes, so
  // a fresh grant out of IDLE does not disturb the fairness order. When no
  // one is left, sel keeps its last value and only the enable drops.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          sel_nxt   = winner;
          hold_nxt  = '0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (end_grant) begin
          ptr_nxt  = sel + 3'd1;
          hold_nxt = '0;
          if (found) begin
            sel_nxt = winner;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          hold_nxt = hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State registers. Reset is asynchronous so an active grant is withdrawn
  // the instant reset_n falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      ptr      <= 3'd0;
      sel      <= 3'd0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      sel      <= sel_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Outputs are decoded straight from registered state, so gnt always
  // agrees with sel/sel_en.
  assign sel_en = (state == GRANT);
  assign busy   = (state == GRANT);
  assign gnt    = sel_en ? (8'b1 << sel) : 8'b0;
  assign done   = end_grant;

endmodule

// File: tb/tb_rr_write_port_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rr_write_port_scheduler
//
// Directed bench for the round-robin write-port scheduler. A default
// instance (MAX_HOLD=4) covers reset, single grant, rotation, wrap-around
// fairness, the sole-requester timeout and mid-grant reset; a second
// instance with MAX_HOLD=1 covers single-cycle grants.
// ---------------------------------------------------------------------------
module tb_rr_write_port_scheduler;

  logic       clock;
  logic       reset_n;
  logic [7:0] req;
  logic [2:0] sel;
  logic       sel_en;
  logic [7:0] gnt;
  logic       done;
  logic       busy;

  logic [7:0] req1;
  logic [2:0] sel1;
  logic       sel_en1;
  logic [7:0] gnt1;
  logic       done1;
  logic       busy1;

  int errors;
  int checks;

  rr_write_port_scheduler #(.MAX_HOLD(4), .CNT_W(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .sel     (sel),
    .sel_en  (sel_en),
    .gnt     (gnt),
    .done    (done),
    .busy    (busy)
  );

  rr_write_port_scheduler #(.MAX_HOLD(1), .CNT_W(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req1),
    .sel     (sel1),
    .sel_en  (sel_en1),
    .gnt     (gnt1),
    .done    (done1),
    .busy    (busy1)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for every check in the bench.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare all outputs of the default instance.
  task automatic checkMain(input string tag, input logic [7:0] exp_gnt,
                           input logic [2:0] exp_sel, input logic exp_en,
                           input logic exp_done);
    checkOutput({tag, ".gnt"},    gnt,           exp_gnt);
    checkOutput({tag, ".sel"},    {5'd0, sel},   {5'd0, exp_sel});
    checkOutput({tag, ".sel_en"}, {7'd0, sel_en}, {7'd0, exp_en});
    checkOutput({tag, ".busy"},   {7'd0, busy},   {7'd0, exp_en});
    checkOutput({tag, ".done"},   {7'd0, done},   {7'd0, exp_done});
  endtask

  // Drive the request vector mid-cycle and let combinational outputs settle.
  task automatic applyStimulus(input logic [7:0] r);
    req = r;
    #1;
  endtask

  // Advance to just after the next rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Reset pulse spanning two rising edges, released away from the edge.
  task automatic pulseReset();
    req     = 8'h00;
    reset_n = 1'b0;
    nextCycle();
    nextCycle();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    req     = 8'hFF;
    req1    = 8'h00;
    reset_n = 1'b0;

    // ---- 1: reset holds everything low even with all requests up ----
    #1;
    for (int c = 0; c < 3; c++) begin
      checkMain("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      nextCycle();
    end
    req = 8'h00;
    #1;
    reset_n = 1'b1;
    nextCycle();
    checkMain("idle_after_reset", 8'h00, 3'd0, 1'b0, 1'b0);

    // ---- 2: single requester 3, request up for two cycles ----
    applyStimulus(8'h08);
    checkMain("single_c0", 8'h00, 3'd0, 1'b0, 1'b0);
    nextCycle();
    checkMain("single_c1", 8'h08, 3'd3, 1'b1, 1'b0);
    nextCycle();
    applyStimulus(8'h00);
    checkMain("single_c2", 8'h08, 3'd3, 1'b1, 1'b1);
    nextCycle();
    checkMain("single_idle", 8'h00, 3'd3, 1'b0, 1'b0);

    // ---- 3: rotation between 0 and 7, four cycles each ----
    pulseReset();
    applyStimulus(8'h81);
    checkMain("rot_c0", 8'h00, 3'd0, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      nextCycle();
      if (((c - 1) / 4) % 2 == 1)
        checkMain($sformatf("rot_c%0d", c), 8'h80, 3'd7, 1'b1, (c % 4) == 0);
      else
        checkMain($sformatf("rot_c%0d", c), 8'h01, 3'd0, 1'b1, (c % 4) == 0);
    end
    applyStimulus(8'h00);
    checkMain("rot_drop", 8'h01, 3'd0, 1'b1, 1'b1);
    nextCycle();
    checkMain("rot_idle", 8'h00, 3'd0, 1'b0, 1'b0);

    // ---- 4: serve 5 (pointer moves to 6), then 8'h43 -> 6, 0, 1 ----
    applyStimulus(8'h20);
    nextCycle();
    checkMain("wrap_serve5", 8'h20, 3'd5, 1'b1, 1'b0);
    applyStimulus(8'h00);
    checkMain("wrap_drop5", 8'h20, 3'd5, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(8'h43);
    checkMain("wrap_idle", 8'h00, 3'd5, 1'b0, 1'b0);
    nextCycle();
    checkMain("wrap_first6", 8'h40, 3'd6, 1'b1, 1'b0);
    applyStimulus(8'h03);
    checkMain("wrap_drop6", 8'h40, 3'd6, 1'b1, 1'b1);
    nextCycle();
    checkMain("wrap_then0", 8'h01, 3'd0, 1'b1, 1'b0);
    applyStimulus(8'h02);
    checkMain("wrap_drop0", 8'h01, 3'd0, 1'b1, 1'b1);
    nextCycle();
    checkMain("wrap_then1", 8'h02, 3'd1, 1'b1, 1'b0);
    applyStimulus(8'h00);
    checkMain("wrap_drop1", 8'h02, 3'd1, 1'b1, 1'b1);
    nextCycle();
    checkMain("wrap_idle_end", 8'h00, 3'd1, 1'b0, 1'b0);

    // ---- 5: sole hog on 5, re-granted after each timeout ----
    applyStimulus(8'h20);
    for (int c = 1; c <= 10; c++) begin
      nextCycle();
      checkMain($sformatf("hog_c%0d", c), 8'h20, 3'd5, 1'b1, (c % 4) == 0);
    end
    applyStimulus(8'h00);
    checkMain("hog_drop", 8'h20, 3'd5, 1'b1, 1'b1);
    nextCycle();
    checkMain("hog_idle", 8'h00, 3'd5, 1'b0, 1'b0);

    // ---- 6: reset in the third cycle of a grant to requester 2 ----
    applyStimulus(8'h04);
    nextCycle();
    nextCycle();
    nextCycle();
    checkMain("midrst_before", 8'h04, 3'd2, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    checkMain("midrst_async", 8'h00, 3'd0, 1'b0, 1'b0);
    nextCycle();
    checkMain("midrst_held", 8'h00, 3'd0, 1'b0, 1'b0);
    reset_n = 1'b1;
    #1;
    checkMain("midrst_release", 8'h00, 3'd0, 1'b0, 1'b0);
    nextCycle();
    checkMain("midrst_regrant", 8'h04, 3'd2, 1'b1, 1'b0);
    applyStimulus(8'h00);
    nextCycle();
    checkMain("midrst_idle", 8'h00, 3'd2, 1'b0, 1'b0);

    // ---- MAX_HOLD=1: every grant is one cycle, done every busy cycle ----
    req1 = 8'h03;
    #1;
    checkOutput("hold1_c0.gnt", gnt1, 8'h00);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      checkOutput($sformatf("hold1_c%0d.gnt", c), gnt1, (c % 2 == 1) ? 8'h01 : 8'h02);
      checkOutput($sformatf("hold1_c%0d.done", c), {7'd0, done1}, 8'h01);
      checkOutput($sformatf("hold1_c%0d.busy", c), {7'd0, busy1}, 8'h01);
    end
    req1 = 8'h00;
    nextCycle();
    checkOutput("hold1_idle.gnt", gnt1, 8'h00);
    checkOutput("hold1_idle.sel", {5'd0, sel1}, 8'h01);
    checkOutput("hold1_idle.done", {7'd0, done1}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
